// File: rtl/alu_arb_pkg.sv
// Shared types, op-code constants and the legality check for the ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ARIT = 1'b1;
  localparam logic OP_LOG  = 1'b0;

  // Arithmetic selectors (OP_ARIT)
  localparam logic [2:0] SEL_ADD  = 3'd0;
  localparam logic [2:0] SEL_SUB  = 3'd1;
  localparam logic [2:0] SEL_SRA  = 3'd2;
  localparam logic [2:0] SEL_SLA  = 3'd3;
  localparam logic [2:0] SEL_ROTA = 3'd4;

  // Logic selectors (OP_LOG)
  localparam logic [2:0] SEL_AND  = 3'd0;
  localparam logic [2:0] SEL_OR   = 3'd1;
  localparam logic [2:0] SEL_XOR  = 3'd2;
  localparam logic [2:0] SEL_SRL  = 3'd3;
  localparam logic [2:0] SEL_SLL  = 3'd4;
  localparam logic [2:0] SEL_ROT  = 3'd5;

  function automatic logic is_illegal(input logic op, input logic [2:0] sel);
    if (op == OP_ARIT) return (sel > SEL_ROTA);
    return (sel > SEL_ROT);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: ptr names the preferred requester.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  logic w_alt;
  assign w_alt = ~ptr;

  always_comb begin
    gnt = 2'b00;
    if (req[ptr])        gnt[ptr]   = 1'b1;
    else if (req[w_alt]) gnt[w_alt] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: grant, execute for one
// cycle, then hold a registered response until the granted side consumes it.
module alu_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req0_sel,
  input  logic [2:0]   req1_sel,
  input  logic         req0_op,
  input  logic         req1_op,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N:0]   rsp_data,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_sel,
  output logic         alu_op,
  input  logic [N:0]   alu_out,
  output logic         busy
);
  import alu_arb_pkg::*;

  state_t       r_state;
  logic         r_ptr;
  logic         r_gidx;
  logic [N-1:0] r_a, r_b;
  logic [2:0]   r_sel;
  logic         r_op;
  logic [N:0]   r_data;
  logic         r_err;
  logic [1:0]   r_rsp_valid;
  logic         r_busy;
  logic [1:0]   w_gnt;
  logic         w_g1;

  rr_arb2 u_rr (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  assign w_g1 = w_gnt[1];

  // Gated by rst_n so nothing is accepted on a reset edge.
  assign req_ready = (rst_n && r_state == IDLE) ? w_gnt : 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_gidx      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= '0;
      r_op        <= 1'b0;
      r_data      <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_a     <= w_g1 ? req1_a   : req0_a;
            r_b     <= w_g1 ? req1_b   : req0_b;
            r_sel   <= w_g1 ? req1_sel : req0_sel;
            r_op    <= w_g1 ? req1_op  : req0_op;
            r_gidx  <= w_g1;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_err       <= is_illegal(r_op, r_sel);
          r_data      <= is_illegal(r_op, r_sel) ? '0 : alu_out;
          r_rsp_valid <= r_gidx ? 2'b10 : 2'b01;
          r_state     <= RESP;
        end
        RESP: begin
          // Only the granted side's ready can complete the response.
          if (rsp_ready[r_gidx]) begin
            r_rsp_valid <= 2'b00;
            r_ptr       <= ~r_gidx;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign alu_op    = r_op;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: external ALU model, transaction-level reference, directed + random stimulus.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [3:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
  logic [2:0] req0_sel = '0, req1_sel = '0;
  logic       req0_op = 1'b0, req1_op = 1'b0;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b00;
  logic [4:0] rsp_data;
  logic       rsp_err;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic       alu_op;
  logic [4:0] alu_out;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_sel(req0_sel), .req1_sel(req1_sel), .req0_op(req0_op), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_op(alu_op),
    .alu_out(alu_out), .busy(busy)
  );

  // Stand-in for the external ALU; illegal codes return junk so zeroing is visible.
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] sel, input logic op);
    logic [3:0] t;
    logic [7:0] d;
    logic [4:0] r;
    d = {a, a} >> b[1:0];
    t = 4'h0;
    r = 5'h1f;
    if (op) begin
      case (sel)
        3'd0: r = {1'b0, a} + {1'b0, b};
        3'd1: r = {1'b0, a} + {1'b0, ~b} + 5'd1;
        3'd2: begin t = $signed(a) >>> b; r = {1'b0, t}; end
        3'd3: begin t = a << b; r = {1'b0, t}; end
        3'd4: r = {1'b0, d[3:0]};
        default: r = 5'h1f;
      endcase
    end else begin
      case (sel)
        3'd0: r = {1'b0, a & b};
        3'd1: r = {1'b0, a | b};
        3'd2: r = {1'b0, a ^ b};
        3'd3: begin t = a >> b; r = {1'b0, t}; end
        3'd4: begin t = a << b; r = {1'b0, t}; end
        3'd5: r = {1'b0, d[3:0]};
        default: r = 5'h1f;
      endcase
    end
    return r;
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_sel, alu_op);

  function automatic logic legal_f(input logic op, input logic [2:0] sel);
    return op ? (sel <= 3'd4) : (sel <= 3'd5);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one outstanding transaction; response visible one cycle after issue.
  logic       m_init = 1'b0, m_out = 1'b0, m_resp = 1'b0, m_g = 1'b0, m_ptr = 1'b0;
  logic [3:0] m_a = '0, m_b = '0;
  logic [2:0] m_sel = '0;
  logic       m_op = 1'b0, m_err = 1'b0;
  logic [4:0] m_data = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init = 1'b1; m_out = 1'b0; m_resp = 1'b0; m_ptr = 1'b0;
      m_a = '0; m_b = '0; m_sel = '0; m_op = 1'b0;
    end else if (m_init) begin
      if (!m_out) begin
        if (req_valid != 2'b00) begin
          m_g    = req_valid[m_ptr] ? m_ptr : ~m_ptr;
          m_a    = m_g ? req1_a : req0_a;
          m_b    = m_g ? req1_b : req0_b;
          m_sel  = m_g ? req1_sel : req0_sel;
          m_op   = m_g ? req1_op : req0_op;
          m_err  = !legal_f(m_op, m_sel);
          m_data = m_err ? 5'd0 : alu_f(m_a, m_b, m_sel, m_op);
          m_out  = 1'b1;
          m_resp = 1'b0;
        end
      end else if (!m_resp) begin
        m_resp = 1'b1;
      end else if (rsp_ready[m_g]) begin
        m_out = 1'b0;
        m_ptr = ~m_g;
      end
    end
  end

  logic       grant_q[$];
  logic       rsp_idx_q[$];
  logic [4:0] rsp_dat_q[$];
  logic       rsp_err_q[$];
  logic [1:0] acc_seen = 2'b00;

  always @(negedge clk) begin : cmp
    logic [1:0] e_rdy, e_vld;
    logic       g;
    if (m_init) begin
      e_rdy = 2'b00;
      g = req_valid[m_ptr] ? m_ptr : ~m_ptr;
      if (rst_n && !m_out && req_valid != 2'b00) e_rdy = g ? 2'b10 : 2'b01;
      e_vld = (m_out && m_resp) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_vld));
      chk("busy", 32'(busy), 32'(m_out));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_sel", 32'(alu_sel), 32'(m_sel));
      chk("alu_op", 32'(alu_op), 32'(m_op));
      if (e_vld != 2'b00) begin
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
    acc_seen = rst_n ? (req_valid & req_ready) : 2'b00;
    if (rst_n && (req_valid & req_ready) != 2'b00) grant_q.push_back(req_ready[1]);
    if (rst_n && (rsp_valid & rsp_ready) != 2'b00) begin
      rsp_idx_q.push_back(rsp_valid[1]);
      rsp_dat_q.push_back(rsp_data);
      rsp_err_q.push_back(rsp_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_q();
    grant_q.delete(); rsp_idx_q.delete(); rsp_dat_q.delete(); rsp_err_q.delete();
  endtask

  task automatic wait_rsp(input int n, input string nm);
    int k;
    k = 0;
    while (rsp_dat_q.size() < n && k < 50) begin tick(); k++; end
    chk(nm, 32'(rsp_dat_q.size() >= n), 32'd1);
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] sel, input logic op);
    if (i == 0) begin req0_a = a; req0_b = b; req0_sel = sel; req0_op = op; end
    else        begin req1_a = a; req1_b = b; req1_sel = sel; req1_op = op; end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);

    // Single add with carry out
    rst_n = 1'b1; clr_q();
    set_req(0, 4'b1111, 4'b1111, 3'b000, 1'b1);
    req_valid = 2'b01;
    #1 chk("t1_req_ready", 32'(req_ready), 32'b01);
    tick(); req_valid = 2'b00;
    chk("t1_busy_exec", 32'(busy), 32'd1);
    tick();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'b01);
    chk("t1_rsp_data", 32'(rsp_data), 32'b11110);
    chk("t1_rsp_err", 32'(rsp_err), 32'd0);
    rsp_ready = 2'b01;
    tick();
    chk("t1_idle", 32'(busy), 32'd0);

    // Both held: strict alternation starting at requester 0
    rst_n = 1'b0; tick(); rst_n = 1'b1; clr_q();
    set_req(0, 4'b0110, 4'b1010, 3'b001, 1'b1);
    set_req(1, 4'b1010, 4'b1111, 3'b010, 1'b0);
    req_valid = 2'b11; rsp_ready = 2'b11;
    wait_rsp(4, "t2_timeout");
    req_valid = 2'b00;
    if (grant_q.size() >= 4 && rsp_dat_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t2_grant", 32'(grant_q[k]), 32'(k % 2));
        chk("t2_rsp_idx", 32'(rsp_idx_q[k]), 32'(k % 2));
        chk("t2_rsp_data", 32'(rsp_dat_q[k]), (k % 2 == 0) ? 32'b01100 : 32'b00101);
      end
    end

    // Backpressure, then shift/rotate via requester 1
    tick(); clr_q();
    rsp_ready = 2'b00;
    set_req(0, 4'b0011, 4'b0100, 3'b000, 1'b1);
    set_req(1, 4'b1010, 4'b0010, 3'b011, 1'b0);
    req_valid = 2'b01;
    tick(); req_valid = 2'b10;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t3_rsp_valid", 32'(rsp_valid), 32'b01);
      chk("t3_rsp_data", 32'(rsp_data), 32'b00111);
      chk("t3_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 2'b11;
    tick();
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_grant1", 32'(req_ready), 32'b10);
    tick(); req_valid = 2'b00;
    wait_rsp(2, "t3_timeout");
    if (rsp_dat_q.size() >= 2) chk("t6_srl", 32'(rsp_dat_q[1]), 32'b00010);
    set_req(1, 4'b0001, 4'b0001, 3'b101, 1'b0);
    req_valid = 2'b10;
    tick(); req_valid = 2'b00;
    wait_rsp(3, "t6_timeout");
    if (rsp_dat_q.size() >= 3) chk("t6_rot", 32'(rsp_dat_q[2]), 32'b01000);

    // Illegal op, then a legal one
    clr_q();
    set_req(0, 4'b1111, 4'b1111, 3'b111, 1'b1);
    req_valid = 2'b01;
    tick(); req_valid = 2'b00;
    wait_rsp(1, "t4_timeout");
    if (rsp_dat_q.size() >= 1) begin
      chk("t4_err", 32'(rsp_err_q[0]), 32'd1);
      chk("t4_data", 32'(rsp_dat_q[0]), 32'd0);
    end
    set_req(0, 4'b0010, 4'b0011, 3'b001, 1'b0);
    req_valid = 2'b01;
    tick(); req_valid = 2'b00;
    wait_rsp(2, "t4b_timeout");
    if (rsp_dat_q.size() >= 2) begin
      chk("t4_or", 32'(rsp_dat_q[1]), 32'b00011);
      chk("t4_or_err", 32'(rsp_err_q[1]), 32'd0);
    end

    // Reset mid-EXEC (pointer currently 1)
    clr_q();
    set_req(0, 4'b0101, 4'b0011, 3'b010, 1'b1);
    req_valid = 2'b01;
    tick(); rst_n = 1'b0; req_valid = 2'b00;
    tick();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rsp_data", 32'(rsp_data), 32'd0);
    chk("t5_alu", 32'({alu_a, alu_b, alu_sel, alu_op}), 32'd0);
    rst_n = 1'b1; req_valid = 2'b11;
    #1 chk("t5_ptr0", 32'(req_ready), 32'b01);
    req_valid = 2'b10;
    #1 chk("t5_req1", 32'(req_ready), 32'b10);
    set_req(1, 4'b0100, 4'b0001, 3'b000, 1'b0);
    tick(); req_valid = 2'b00;
    wait_rsp(1, "t5_timeout");
    chk("t5_no_abort_rsp", 32'(rsp_dat_q.size()), 32'd1);
    if (rsp_idx_q.size() >= 1) chk("t5_rsp_idx", 32'(rsp_idx_q[0]), 32'd1);

    // Randomized traffic with backpressure and occasional reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!req_valid[0] || acc_seen[0]) begin
        req_valid[0] = ($urandom_range(0, 2) != 0);
        set_req(0, 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
      end
      if (!req_valid[1] || acc_seen[1]) begin
        req_valid[1] = ($urandom_range(0, 2) != 0);
        set_req(1, 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
      end
      rsp_ready = 2'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU (`MuxOperaciones`) between two requesters.
- Round-robin arbitration selects one requester at a time; the block latches that requester's operands and drives the ALU.
- The ALU result is registered and returned to the granted requester over a valid/ready response handshake.
- Sits between the control/FSM layer and the ALU; it owns the ALU's A, B, selector and operacion inputs.

Parameters:
- N, 4, operand width; ALU result width is N+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  2  request valid, bit i = requester i.
- req_ready  out  2  request accepted this cycle, one-hot or zero.
- req0_a, req1_a  in  N  operand A per requester.
- req0_b, req1_b  in  N  operand B or shift amount per requester.
- req0_sel, req1_sel  in  3  ALU selector per requester.
- req0_op, req1_op  in  1  ALU operacion per requester; 1 = arithmetic, 0 = logic.
- rsp_valid  out  2  response valid, bit i = requester i, at most one set.
- rsp_ready  in  2  response consumed.
- rsp_data  out  N+1  registered ALU result.
- rsp_err  out  1  illegal operation code flag, qualified by rsp_valid.
- alu_a, alu_b  out  N  to ALU A, B.
- alu_sel  out  3  to ALU selector.
- alu_op  out  1  to ALU operacion.
- alu_out  in  N+1  from ALU out; combinational.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs and registers update on the rising edge of clk.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, priority pointer=0, req_ready=0, rsp_valid=0.
  - rsp_data=0, rsp_err=0, busy=0.
  - alu_a, alu_b, alu_sel, alu_op = 0.
  - Reset wins over every other event, including mid-operation; an in-flight op is dropped silently with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, grant per round-robin: the pointer names the preferred requester; if it is not valid, the other one is granted.
  - req_ready[grant] is asserted combinationally in this same cycle; acceptance is req_valid & req_ready.
  - At the edge: latch operands, sel and op into the operand register; latch the grant index; go to EXEC.
  - No req_valid: stay in IDLE.
- EXEC (1 cycle):
  - alu_* are driven from the operand register; alu_out is combinational and settles within the cycle.
  - At the edge: rsp_data <= alu_out, rsp_err <= illegal(op,sel); go to RESP.
  - If illegal, rsp_data <= 0.
- RESP:
  - rsp_valid[grant] = 1; rsp_data and rsp_err are held stable until the handshake.
  - On rsp_ready[grant]=1: go to IDLE and set pointer <= ~grant.
  - rsp_ready on the non-granted bit is ignored.
- Latency: acceptance at edge T produces rsp_valid at cycle T+2. Minimum issue interval is 3 cycles; no overlap of operations.
- req_ready is 0 in EXEC and RESP. Requesters must hold their request until accepted.
- alu_* hold the last latched values in IDLE and RESP; they are not zeroed between operations.
- Legal ops:
  - op=1, sel 000..100: add, sub, sra, sla, rotate.
  - op=0, sel 000..101: and, or, xor, srl, sll, rotate.
  - Anything else is illegal.
- rsp_data carries the full N+1 bits, including the add carry bit and the ALU's zero-extended top bit for logic ops. No width truncation.
- Simultaneous req_valid=2'b11: the pointer decides; strict alternation is guaranteed while both are held.
- The pointer updates only on a completed response, never on reset-aborted ops.

Decomposition:
- Package alu_arb_pkg:
  - state_t enum {IDLE, EXEC, RESP}.
  - Op-code constants: OP_ARIT=1'b1, OP_LOG=1'b0, SEL_ADD..SEL_ROT.
  - Function is_illegal(op,sel).
- Sub-module rr_arb2: inputs req[1:0] and ptr; output one-hot gnt[1:0]. Purely combinational.
- The ALU stays outside this block and is connected at the parent level.

Test Plan:
- Reset, then req_valid=01, req0 = {A=1111, B=1111, op=1, sel=000} -> req_ready=01 the same cycle; rsp_valid=01 two cycles later; rsp_data=11110, rsp_err=0.
- req_valid=11 held; req0 = 0110 - 1010 (op1 sel001), req1 = 1010 xor 1111 (op0 sel010); rsp_ready tied 11 -> grants alternate 0,1,0,1. Responses: req0 gets 01100, req1 gets 00101.
- Backpressure: response pending with rsp_ready=00 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=00 throughout. Raising rsp_ready -> IDLE the next cycle.
- Illegal op: op=1, sel=111 -> rsp_err=1, rsp_data=00000, arbitration continues normally afterward.
- Reset mid-EXEC -> next cycle all outputs 0, pointer=0, no rsp_valid. A subsequent req1 alone is granted.
- Logic shift and rotate via req1: A=1010, B=0010, op0 sel011 -> 00010; A=0001, op0 sel101 -> 01000.
